// File: rtl/data_sb_pkg.sv
// Shared definitions for the data-side store buffer: default geometry and
// the buffered store entry type used by the top and the forwarding matcher.
// The entry type fixes address/data widths at the package defaults.
package data_sb_pkg;

  localparam int SB_DEPTH  = 4;
  localparam int SB_ADDR_W = 16;
  localparam int SB_DATA_W = 16;

  typedef struct packed {
    logic                 valid;
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/data_store_buffer_sb_match.sv
// sb_match: combinational youngest-first address matcher over the store
// buffer. Entries are visited oldest to youngest starting at the head, so the
// last matching entry seen (the one closest to the tail) supplies the data.
module sb_match
  import data_sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  sb_entry_t              entries [DEPTH],
  input  logic [IDX_W-1:0]       head,
  input  logic [IDX_W:0]         count,
  input  logic [SB_ADDR_W-1:0]   addr,
  output logic                   hit,
  output logic [SB_DATA_W-1:0]   data
);

  logic [IDX_W-1:0] idx;

  // Priority scan in age order; a later (younger) match overrides an older one
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + k[IDX_W-1:0];
      if (({1'b0, k[IDX_W-1:0]} < count) && entries[idx].valid &&
          (entries[idx].addr == addr)) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/data_store_buffer.sv
// data_store_buffer: in-order store buffer between execute and data memory.
// Stores are queued and drained over a valid/ready write port; loads resolve
// in the same cycle. Optional macro STORE_FWD_EN enables youngest-match
// forwarding; without it, a load that hits a buffered store stalls until all
// matching entries have drained and then reads memory.
module data_store_buffer
  import data_sb_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] aluOutput,
  input  logic              MemWriteE,
  input  logic              MemReadE,
  input  logic [DATA_W-1:0] ReadData2E,
  output logic [DATA_W-1:0] dataOut,
  output logic              stallMem,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wvalid,
  input  logic              mem_wready,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] PTR_ONE  = IDX_W'(1);
  localparam logic [IDX_W:0]   CNT_ONE  = (IDX_W+1)'(1);
  localparam logic [IDX_W:0]   CNT_FULL = (IDX_W+1)'(DEPTH);

  sb_entry_t        entries [DEPTH];
  logic [IDX_W-1:0] headPtr;
  logic [IDX_W-1:0] tailPtr;
  logic [IDX_W:0]   count;
  logic             full;
  logic             hit;
  logic [DATA_W-1:0] fwdData;
  logic             enq;
  logic             deq;

  sb_match #(.DEPTH(DEPTH), .IDX_W(IDX_W)) uMatch (
    .entries (entries),
    .head    (headPtr),
    .count   (count),
    .addr    (aluOutput),
    .hit     (hit),
    .data    (fwdData)
  );

  assign full       = (count == CNT_FULL);
  assign mem_wvalid = (count != '0);
  assign mem_waddr  = entries[headPtr].addr;
  assign mem_wdata  = entries[headPtr].data;
  assign mem_raddr  = aluOutput;
  assign enq        = MemWriteE & ~stallMem;
  assign deq        = mem_wvalid & mem_wready;

`ifdef STORE_FWD_EN
  // Loads forward from the youngest matching store, otherwise read memory
  always_comb begin
    stallMem = MemWriteE & full;
    dataOut  = hit ? fwdData : mem_rdata;
  end
`else
  // No forwarding path: a load that hits a buffered store waits for it to drain
  always_comb begin
    stallMem = (MemWriteE & full) | (MemReadE & hit);
    dataOut  = mem_rdata;
  end
`endif

  // FIFO state: enqueue at tail, dequeue at head; head and tail never collide
  // on the same edge because that needs both empty-and-draining or full-and-accepting
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
    end else begin
      if (deq) begin
        entries[headPtr].valid <= 1'b0;
        headPtr                <= headPtr + PTR_ONE;
      end
      if (enq) begin
        entries[tailPtr] <= '{valid: 1'b1, addr: aluOutput, data: ReadData2E};
        tailPtr          <= tailPtr + PTR_ONE;
      end
      if (enq && !deq)
        count <= count + CNT_ONE;
      else if (deq && !enq)
        count <= count - CNT_ONE;
    end
  end

endmodule
